// File: rtl/decode_hazard_stage.sv
// -----------------------------------------------------------------------------
// decode_hazard_stage
//   MIPS instruction-decode stage with ID/EX pipeline register.
//   - REG_COUNT-entry register file, write-through bypass, r0 hard-wired to 0
//   - main control decode (R-type, lw, sw, beq, addi; anything else is a nop)
//   - 16-bit immediate sign-extended to DATA_W
//   - load-use hazard detection: inserts a bubble and asks IF to hold
//   - flush squashes the instruction in decode (taken branch)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   wb_reg_write              writeback register-write enable
//   wb_write_reg_location     writeback destination register (REG_AW bits)
//   mem_wb_write_data         writeback data
//   if_id_instr, if_id_npc    instruction / next PC from IF/ID
//   flush                     squash the instruction in decode
//   hazard_stall              combinational hold request to IF
//   id_ex_wb                  {RegWrite, MemtoReg}
//   id_ex_mem                 {Branch, MemRead, MemWrite}
//   id_ex_execute             {RegDst, ALUOp[1:0], ALUSrc}
//   id_ex_npc                 registered next PC
//   id_ex_readdat1/2          registered rs / rt values
//   id_ex_sign_ext            sign-extended immediate
//   id_ex_instr_bits_*        full 5-bit rs / rt / rd fields for forwarding
// -----------------------------------------------------------------------------
module decode_hazard_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    parameter int NPC_W     = 32,
    localparam int REG_AW   = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg_location,
    input  logic [DATA_W-1:0] mem_wb_write_data,
    input  logic [31:0]       if_id_instr,
    input  logic [NPC_W-1:0]  if_id_npc,
    input  logic              flush,
    output logic              hazard_stall,
    output logic [1:0]        id_ex_wb,
    output logic [2:0]        id_ex_mem,
    output logic [3:0]        id_ex_execute,
    output logic [NPC_W-1:0]  id_ex_npc,
    output logic [DATA_W-1:0] id_ex_readdat1,
    output logic [DATA_W-1:0] id_ex_readdat2,
    output logic [DATA_W-1:0] id_ex_sign_ext,
    output logic [4:0]        id_ex_instr_bits_2521,
    output logic [4:0]        id_ex_instr_bits_2016,
    output logic [4:0]        id_ex_instr_bits_1511
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] mem;
        logic [3:0] ex;
    } ctrl_t;

    logic [DATA_W-1:0] regs [REG_COUNT];

    logic [5:0]        opcode;
    logic [4:0]        f_rs, f_rt, f_rd;
    logic [REG_AW-1:0] ra1, ra2;
    logic              wr_valid;
    logic [DATA_W-1:0] rd1, rd2;
    ctrl_t             ctrl;
    logic              uses_rt;

    assign opcode = if_id_instr[31:26];
    assign f_rs   = if_id_instr[25:21];
    assign f_rt   = if_id_instr[20:16];
    assign f_rd   = if_id_instr[15:11];
    assign ra1    = f_rs[REG_AW-1:0];
    assign ra2    = f_rt[REG_AW-1:0];

    // Writes to r0 are dropped, so a valid write never targets r0.
    assign wr_valid = wb_reg_write && (wb_write_reg_location != '0);

    // Read ports: r0 is zero, same-cycle write is bypassed, out-of-range
    // indices (non power-of-two REG_COUNT) read as zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) begin
            if (wr_valid && wb_write_reg_location == ra1) rd1 = mem_wb_write_data;
            else if (int'(ra1) < REG_COUNT)               rd1 = regs[ra1];
        end
        if (ra2 != '0) begin
            if (wr_valid && wb_write_reg_location == ra2) rd2 = mem_wb_write_data;
            else if (int'(ra2) < REG_COUNT)               rd2 = regs[ra2];
        end
    end

    always_comb begin
        ctrl = '0;
        unique case (opcode)
            OP_RTYPE: ctrl = '{wb: 2'b10, mem: 3'b000, ex: 4'b1100};
            OP_LW:    ctrl = '{wb: 2'b11, mem: 3'b010, ex: 4'b0001};
            OP_SW:    ctrl = '{wb: 2'b00, mem: 3'b001, ex: 4'b0001};
            OP_BEQ:   ctrl = '{wb: 2'b00, mem: 3'b100, ex: 4'b0010};
            OP_ADDI:  ctrl = '{wb: 2'b10, mem: 3'b000, ex: 4'b0001};
            default:  ctrl = '0;
        endcase
    end

    // Only R-type, sw and beq actually source rt; lw/addi overwrite it.
    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

    // Load in EX whose destination feeds the instruction in decode. The bubble
    // clears MemRead, so this self-cancels after one cycle.
    assign hazard_stall = !rst && !flush && id_ex_mem[1] &&
                          (id_ex_instr_bits_2016 != 5'd0) &&
                          ((id_ex_instr_bits_2016 == f_rs) ||
                           ((id_ex_instr_bits_2016 == f_rt) && uses_rt));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wr_valid && int'(wb_write_reg_location) < REG_COUNT) begin
            regs[wb_write_reg_location] <= mem_wb_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_wb              <= '0;
            id_ex_mem             <= '0;
            id_ex_execute         <= '0;
            id_ex_npc             <= '0;
            id_ex_readdat1        <= '0;
            id_ex_readdat2        <= '0;
            id_ex_sign_ext        <= '0;
            id_ex_instr_bits_2521 <= '0;
            id_ex_instr_bits_2016 <= '0;
            id_ex_instr_bits_1511 <= '0;
        end else begin
            // Bubble: controls only; data and fields still load.
            if (flush || hazard_stall) begin
                id_ex_wb      <= '0;
                id_ex_mem     <= '0;
                id_ex_execute <= '0;
            end else begin
                id_ex_wb      <= ctrl.wb;
                id_ex_mem     <= ctrl.mem;
                id_ex_execute <= ctrl.ex;
            end
            id_ex_npc             <= if_id_npc;
            id_ex_readdat1        <= rd1;
            id_ex_readdat2        <= rd2;
            id_ex_sign_ext        <= DATA_W'($signed(if_id_instr[15:0]));
            id_ex_instr_bits_2521 <= f_rs;
            id_ex_instr_bits_2016 <= f_rt;
            id_ex_instr_bits_1511 <= f_rd;
        end
    end

endmodule

// File: tb/tb_decode_hazard_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard_stage
//   Directed self-checking bench. Two instances share stimulus: the default
//   configuration (a) and a DATA_W=64 / REG_COUNT=8 configuration (b).
// -----------------------------------------------------------------------------
module tb_decode_hazard_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_reg_write;
    logic [4:0]  wb_loc;
    logic [63:0] wb_data;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        flush;

    logic        a_stall, b_stall;
    logic [1:0]  a_wb, b_wb;
    logic [2:0]  a_mem, b_mem;
    logic [3:0]  a_ex, b_ex;
    logic [31:0] a_npc, b_npc;
    logic [31:0] a_rd1, a_rd2, a_sx;
    logic [63:0] b_rd1, b_rd2, b_sx;
    logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_hazard_stage dut_a (
        .clk(clk), .rst(rst),
        .wb_reg_write(wb_reg_write), .wb_write_reg_location(wb_loc),
        .mem_wb_write_data(wb_data[31:0]),
        .if_id_instr(instr), .if_id_npc(npc), .flush(flush),
        .hazard_stall(a_stall),
        .id_ex_wb(a_wb), .id_ex_mem(a_mem), .id_ex_execute(a_ex),
        .id_ex_npc(a_npc), .id_ex_readdat1(a_rd1), .id_ex_readdat2(a_rd2),
        .id_ex_sign_ext(a_sx),
        .id_ex_instr_bits_2521(a_rs), .id_ex_instr_bits_2016(a_rt),
        .id_ex_instr_bits_1511(a_rd)
    );

    decode_hazard_stage #(.DATA_W(64), .REG_COUNT(8), .NPC_W(32)) dut_b (
        .clk(clk), .rst(rst),
        .wb_reg_write(wb_reg_write), .wb_write_reg_location(wb_loc[2:0]),
        .mem_wb_write_data(wb_data),
        .if_id_instr(instr), .if_id_npc(npc), .flush(flush),
        .hazard_stall(b_stall),
        .id_ex_wb(b_wb), .id_ex_mem(b_mem), .id_ex_execute(b_ex),
        .id_ex_npc(b_npc), .id_ex_readdat1(b_rd1), .id_ex_readdat2(b_rd2),
        .id_ex_sign_ext(b_sx),
        .id_ex_instr_bits_2521(b_rs), .id_ex_instr_bits_2016(b_rt),
        .id_ex_instr_bits_1511(b_rd)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle off the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic [8:0] exp);
        check(tag, {55'd0, a_wb, a_mem, a_ex}, {55'd0, exp});
    endtask

    initial begin
        rst = 1'b1; wb_reg_write = 1'b0; wb_loc = '0; wb_data = '0;
        instr = 32'h00A41020; npc = 32'd7; flush = 1'b0;

        // Reset for two edges
        tick(); tick();
        check_ctrl("reset_ctrl", 9'b00_000_0000);
        check("reset_npc",   a_npc, 0);
        check("reset_rd1",   a_rd1, 0);
        check("reset_sx",    a_sx, 0);
        check("reset_rs",    a_rs, 0);
        check("reset_stall", a_stall, 0);
        check("reset_b_sx",  b_sx, 0);

        // First decode: add $2,$5,$4
        rst = 1'b0; instr = 32'h00A41020; npc = 32'd1;
        tick();
        check_ctrl("rtype_ctrl", 9'b10_000_1100);
        check("rtype_rs",  a_rs, 5);
        check("rtype_rt",  a_rt, 4);
        check("rtype_rd",  a_rd, 2);
        check("rtype_rd1", a_rd1, 0);
        check("rtype_rd2", a_rd2, 0);
        check("rtype_npc", a_npc, 1);
        check("rtype_sx",  a_sx, 32'h00001020);

        // Bypass: write r2 in the same cycle it is read
        wb_reg_write = 1'b1; wb_loc = 5'd2; wb_data = 64'h64; instr = 32'h00421020;
        tick();
        check("bypass_rd1", a_rd1, 32'h64);
        check("bypass_rd2", a_rd2, 32'h64);

        // Same read from storage
        wb_reg_write = 1'b0;
        tick();
        check("stored_rd1", a_rd1, 32'h64);

        // r0 write is dropped
        wb_reg_write = 1'b1; wb_loc = 5'd0; wb_data = 64'hFFFF; instr = 32'h00008000;
        tick();
        check("r0_rd1", a_rd1, 0);
        check("r0_rd2", a_rd2, 0);
        check("r0_rd",  a_rd, 16);
        check("r0_sx",  a_sx, 32'hFFFF8000);
        wb_reg_write = 1'b0;

        // Load-use: lw $2,2($4) then add $2,$2,$2
        instr = 32'h8C820002;
        tick();
        check_ctrl("lw_ctrl", 9'b11_010_0001);
        instr = 32'h00421020;
        #1;
        check("lu_stall", a_stall, 1);
        tick();
        check_ctrl("lu_bubble", 9'b00_000_0000);
        check("lu_bubble_rs", a_rs, 2);
        check("lu_stall_drop", a_stall, 0);
        tick();
        check_ctrl("lu_add", 9'b10_000_1100);

        // No hazard when the dependent instruction does not use r2
        instr = 32'h8C820002;
        tick();
        instr = 32'h00A41020;
        #1;
        check("nohaz_stall", a_stall, 0);
        tick();
        check_ctrl("nohaz_ctrl", 9'b10_000_1100);

        // Flush a beq
        instr = 32'h10000008; npc = 32'h40; flush = 1'b1;
        tick();
        check_ctrl("flush_ctrl", 9'b00_000_0000);
        check("flush_sx",  a_sx, 32'h8);
        check("flush_npc", a_npc, 32'h40);
        flush = 1'b0;

        // Flush overrides a load-use hazard
        instr = 32'h8C820002;
        tick();
        instr = 32'h00421020; flush = 1'b1;
        #1;
        check("flush_haz_stall", a_stall, 0);
        flush = 1'b0;
        #1;
        check("haz_unflushed", a_stall, 1);
        flush = 1'b1;
        tick();
        check_ctrl("flush_haz_ctrl", 9'b00_000_0000);
        flush = 1'b0;

        // Sign extension, both widths
        instr = 32'h8C82FFFC;
        tick();
        check("sx32", a_sx, 32'hFFFFFFFC);
        check("sx64", b_sx, 64'hFFFFFFFFFFFFFFFC);

        // REG_COUNT=8: field 10 aliases register 2
        wb_reg_write = 1'b1; wb_loc = 5'd2; wb_data = 64'h123456789ABCDEF0;
        instr = 32'h01400000;
        #1;
        check("alias_nostall", a_stall, 0);
        tick();
        check("alias_b_bypass", b_rd1, 64'h123456789ABCDEF0);
        check("alias_a_r10",    a_rd1, 0);
        check("alias_b_rs",     b_rs, 10);
        wb_reg_write = 1'b0;
        tick();
        check("alias_b_stored", b_rd1, 64'h123456789ABCDEF0);

        // Reset asserted mid-stall
        instr = 32'h8C820002;
        tick();
        instr = 32'h00421020;
        #1;
        check("rst_pre_stall", a_stall, 1);
        rst = 1'b1;
        #1;
        check("rst_stall_drop", a_stall, 0);
        tick();
        check_ctrl("rst_mid_ctrl", 9'b00_000_0000);
        check("rst_mid_npc", a_npc, 0);
        check("rst_mid_rt",  a_rt, 0);
        rst = 1'b0;
        tick();
        check("rst_rf_cleared", a_rd1, 0);
        check("rst_rf_b",       b_rd1, 0);
        check_ctrl("rst_after", 9'b10_000_1100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
